// File: rtl/click_classifier.sv
// Groups stabilized press pulses into single/double/triple click strobes.
// Optional CLICK_TRIPLE_EN adds the GOT2 state and the triple_out strobe.
module click_classifier #(
  parameter int WINDOW = 25_000_000,
  parameter int CNT_W  = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pulse_in,
  output logic       single_out,
  output logic       double_out,
  output logic       triple_out,
  output logic       busy,
  output logic [7:0] event_count
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] GOT1 = 2'd1;
`ifdef CLICK_TRIPLE_EN
  localparam logic [1:0] GOT2 = 2'd2;
`endif

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             timeout;

  // Window closes on the WINDOW-th cycle after the accepted press.
  assign timeout = (cnt == CNT_W'(WINDOW - 1)) && !pulse_in;
  assign busy    = (state != IDLE);

`ifdef CLICK_TRIPLE_EN
  logic triple_q;
  assign triple_out = triple_q;
`else
  assign triple_out = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      single_out  <= 1'b0;
      double_out  <= 1'b0;
      event_count <= 8'd0;
`ifdef CLICK_TRIPLE_EN
      triple_q    <= 1'b0;
`endif
    end else begin
      single_out <= 1'b0;
      double_out <= 1'b0;
`ifdef CLICK_TRIPLE_EN
      triple_q   <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (pulse_in) begin
            state <= GOT1;
            cnt   <= '0;
          end
        end
        GOT1: begin
          if (pulse_in) begin
            cnt <= '0;
`ifdef CLICK_TRIPLE_EN
            state <= GOT2;
`else
            state       <= IDLE;
            double_out  <= 1'b1;
            event_count <= event_count + 8'd1;
`endif
          end else if (timeout) begin
            state       <= IDLE;
            cnt         <= '0;
            single_out  <= 1'b1;
            event_count <= event_count + 8'd1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef CLICK_TRIPLE_EN
        GOT2: begin
          if (pulse_in) begin
            state       <= IDLE;
            cnt         <= '0;
            triple_q    <= 1'b1;
            event_count <= event_count + 8'd1;
          end else if (timeout) begin
            state       <= IDLE;
            cnt         <= '0;
            double_out  <= 1'b1;
            event_count <= event_count + 8'd1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
